// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encoding and the iteration-counter width helper.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter must hold values 0..width, hence clog2(width)+1 bits.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, shared with the multi-operand adder datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/ripple_subtractor.sv
// Ripple-borrow subtractor a - b built as a + ~b + 1 from full_adder cells.
// cout = 1 means no borrow, i.e. a >= b.
module ripple_subtractor #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             cout
);

  logic [WIDTH:0] carry;

  // The +1 of the two's complement comes in through the chain's carry-in.
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (~b[i]),
      .cin  (carry[i]),
      .sum  (diff[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock behind a
// start/done handshake. Divide-by-zero short-circuits straight to DONE.
module seq_restoring_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] q;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   diff;
  logic             no_borrow;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;
  logic             last_iter;

  // After every restoring step R < D, so R's top bit is always zero and is
  // shifted out unread; this tap just marks it as intentionally unused.
  logic             unused_r_msb;
  assign unused_r_msb = r[WIDTH];

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  assign r_shift = {r[WIDTH-1:0], q[WIDTH-1]};

  ripple_subtractor #(
    .WIDTH (WIDTH + 1)
  ) u_sub (
    .a    (r_shift),
    .b    ({1'b0, d}),
    .diff (diff),
    .cout (no_borrow)
  );

  assign r_next    = no_borrow ? diff : r_shift;
  assign q_next    = {q[WIDTH-2:0], no_borrow};
  assign last_iter = (count == CW'(WIDTH - 1));

  // Control FSM plus datapath registers; result outputs are registered and
  // only change when a division enters DONE.
  // NOTE: non-blocking (<=) everywhere here so every register samples the
  // pre-edge values; blocking would let later lines see already-updated state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      q           <= '0;
      r           <= '0;
      d           <= '0;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              q     <= dividend;
              r     <= '0;
              d     <= divisor;
              count <= '0;
              busy  <= 1'b1;
              state <= CALC;
            end else begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end
          end
        end
        CALC: begin
          r     <= r_next;
          q     <= q_next;
          count <= count + 1'b1;
          if (last_iter) begin
            quotient    <= q_next;
            remainder   <= r_next[WIDTH-1:0];
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider at WIDTH=4: directed table,
// handshake corner sequences, and a shuffled sweep of all operand pairs.
module tb_seq_restoring_divider;

  localparam int W       = 4;
  localparam int TIMEOUT = 20;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_vec  = 0;
  int n_fail = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int dz;
    int lat;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer division; a zero divisor yields all-ones / dividend.
  function automatic void ref_div(input int a, input int b,
                                  output int q, output int r,
                                  output int dz, output int lat);
    if (b == 0) begin
      q = (1 << W) - 1; r = a; dz = 1; lat = 0;
    end else begin
      q = a / b; r = a % b; dz = 0; lat = W;
    end
  endfunction

  // Issue one division (entered and left at posedge+1) and check every result.
  // lat counts post-edge samples after the accept edge until done is seen.
  task automatic check_op(input string tag, input int a, input int b,
                          input int eq, input int er, input int edz, input int elat);
    int lat, bcnt, ov;
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; bcnt = 0; ov = 0;
    while (!done && lat < TIMEOUT) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (busy && done) ov = 1;
    check({tag, " done_seen"}, int'(done), 1);
    check({tag, " quotient"}, int'(quotient), eq);
    check({tag, " remainder"}, int'(remainder), er);
    check({tag, " div_by_zero"}, int'(div_by_zero), edz);
    check({tag, " latency"}, lat, elat);
    check({tag, " busy_cycles"}, bcnt, elat);
    check({tag, " busy_done_overlap"}, ov, 0);
    @(posedge clk); #1;
    check({tag, " done_one_cycle"}, int'(done), 0);
  endtask

  // Bounded wait for done; returns number of samples taken.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < TIMEOUT) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  vec_t vecs[10];
  int   order[256];

  initial begin
    int n, seen, tmp, j, eq, er, edz, elat;

    vecs[0] = '{13,  4,  3, 1, 0, W};
    vecs[1] = '{15,  1, 15, 0, 0, W};
    vecs[2] = '{ 7,  9,  0, 7, 0, W};
    vecs[3] = '{ 5,  0, 15, 5, 1, 0};
    vecs[4] = '{ 0,  7,  0, 0, 0, W};
    vecs[5] = '{15, 15,  1, 0, 0, W};
    vecs[6] = '{ 0,  0, 15, 0, 1, 0};
    vecs[7] = '{14,  3,  4, 2, 0, W};
    vecs[8] = '{15,  2,  7, 1, 0, W};
    vecs[9] = '{ 1, 15,  0, 1, 0, W};

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    @(posedge clk); #1;
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst quotient", int'(quotient), 0);
    check("rst remainder", int'(remainder), 0);
    check("rst div_by_zero", int'(div_by_zero), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 10; i++)
      check_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
               vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].lat);

    // start pulsed during CALC and then held through DONE.
    dividend = 4'd13; divisor = 4'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    dividend = 4'd9; divisor = 3'd3; start = 1'b1;
    wait_done(n);
    check("held first done_seen", int'(done), 1);
    check("held first latency", n + 1, W);
    check("held first quotient", int'(quotient), 3);
    check("held first remainder", int'(remainder), 1);
    @(posedge clk); #1;
    check("held ignored in DONE busy", int'(busy), 0);
    check("held ignored in DONE done", int'(done), 0);
    @(posedge clk); #1;
    check("held accepted busy", int'(busy), 1);
    check("held result kept quotient", int'(quotient), 3);
    check("held result kept remainder", int'(remainder), 1);
    start = 1'b0;
    wait_done(n);
    check("held second done_seen", int'(done), 1);
    check("held second quotient", int'(quotient), 3);
    check("held second remainder", int'(remainder), 0);
    @(posedge clk); #1;

    // Reset in the middle of 12/5 (after accept+2).
    dividend = 4'd12; divisor = 4'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort quotient", int'(quotient), 0);
    check("abort remainder", int'(remainder), 0);
    check("abort div_by_zero", int'(div_by_zero), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 2 * W; c++) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    check("abort no done", seen, 0);
    check_op("after_abort", 12, 5, 2, 2, 0, W);

    // Shuffled sweep of every operand pair with random idle gaps.
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      ref_div(order[i] / 16, order[i] % 16, eq, er, edz, elat);
      check_op($sformatf("rnd %0d/%0d", order[i] / 16, order[i] % 16),
               order[i] / 16, order[i] % 16, eq, er, edz, elat);
      repeat ($urandom_range(2, 0)) begin
        @(posedge clk); #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
